col_cmd_issuer: RTL and testbench

- Initiator side of the compute-unit command interface.
- Pulls paired operands from two column streams (A, B) and drives in1/in2/cmd to the compute unit, one element per cycle.
- Captures the unit's 1-bit result one cycle later and packs the bits into MASK_W-bit mask words.
- Emits mask words on a valid/ready stream toward the result writer. Sits between the column readers and the result DMA.

---
 rtl/col_cmd_issuer_pkg.sv | 22 ++
 rtl/col_cmd_issuer_mask_packer.sv | 64 ++++++
 rtl/col_cmd_issuer.sv | 131 +++++++++++++
 tb/tb_col_cmd_issuer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/col_cmd_issuer_pkg.sv
// rtl/col_cmd_issuer_pkg.sv - shared widths, opcodes and FSM states for the column command issuer
package col_cmd_issuer_pkg;

  localparam int DEF_NUM_SIZE      = 32;
  localparam int DEF_CMD_SIZE_LOG2 = 3;
  localparam int DEF_CMD_W         = 2 ** DEF_CMD_SIZE_LOG2;

  typedef enum logic [DEF_CMD_W-1:0] {
    NOOP   = 8'd0,
    CMP_EQ = 8'd1,
    CMP_LT = 8'd2,
    CMP_GT = 8'd3
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } issuer_state_t;

endpackage

// File: rtl/col_cmd_issuer_mask_packer.sv
// rtl/col_cmd_issuer_mask_packer.sv - shifts result bits into a pack word and hands full/final words to a valid/ready hold register
module col_cmd_issuer_mask_packer #(
  parameter int MASK_W = 32,
  localparam int CNT_W = $clog2(MASK_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              shift_bit,
  input  logic              flush,
  input  logic              mask_ready,
  output logic [CNT_W-1:0]  pack_cnt,
  output logic              move,
  output logic              hold_free,
  output logic [MASK_W-1:0] mask_data,
  output logic [CNT_W-1:0]  mask_count,
  output logic              mask_valid
);

  logic [MASK_W-1:0] pack;
  logic [MASK_W-1:0] cap_data;
  logic [CNT_W-1:0]  cap_cnt;
  logic              full;

  // Pack contents as they will be once this cycle's result bit lands.
  always_comb begin
    cap_data = pack;
    cap_cnt  = pack_cnt;
    if (shift_en) begin
      cap_data[pack_cnt[CNT_W-2:0]] = shift_bit;
      cap_cnt = pack_cnt + CNT_W'(1);
    end
  end

  assign full      = (cap_cnt == CNT_W'(MASK_W));
  assign hold_free = !mask_valid || mask_ready;
  // A partial word only leaves on flush; the issuer guarantees a full word never waits.
  assign move      = hold_free && (full || (flush && (cap_cnt != '0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      pack       <= '0;
      pack_cnt   <= '0;
      mask_data  <= '0;
      mask_count <= '0;
      mask_valid <= 1'b0;
    end else if (move) begin
      pack       <= '0;
      pack_cnt   <= '0;
      mask_data  <= cap_data;
      mask_count <= cap_cnt;
      mask_valid <= 1'b1;
    end else begin
      pack     <= cap_data;
      pack_cnt <= cap_cnt;
      if (mask_valid && mask_ready) begin
        mask_valid <= 1'b0;
        mask_data  <= '0;
        mask_count <= '0;
      end
    end
  end

endmodule

// File: rtl/col_cmd_issuer.sv
// rtl/col_cmd_issuer.sv - pulls paired column operands, issues them to the compute unit and packs its 1-bit results
// Optional: COL_ISSUER_POPCOUNT_EN adds match_count, the running count of captured 1 bits.
module col_cmd_issuer
  import col_cmd_issuer_pkg::*;
#(
  parameter int NUM_SIZE      = DEF_NUM_SIZE,
  parameter int CMD_SIZE_LOG2 = DEF_CMD_SIZE_LOG2,
  parameter int MASK_W        = 32,
  parameter int LEN_W         = 16,
  localparam int CMD_W        = 2 ** CMD_SIZE_LOG2,
  localparam int CNT_W        = $clog2(MASK_W) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [CMD_W-1:0]    op_cmd,
  input  logic [NUM_SIZE-1:0] a_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [NUM_SIZE-1:0] b_data,
  input  logic                b_valid,
  output logic                b_ready,
  output logic [NUM_SIZE-1:0] dut_in1,
  output logic [NUM_SIZE-1:0] dut_in2,
  output logic [CMD_W-1:0]    dut_cmd,
  input  logic                dut_out,
  output logic [MASK_W-1:0]   mask_data,
  output logic [CNT_W-1:0]    mask_count,
  output logic                mask_valid,
  input  logic                mask_ready,
  output logic                busy,
  output logic                done
`ifdef COL_ISSUER_POPCOUNT_EN
  ,
  output logic [LEN_W-1:0]    match_count
`endif
);

  issuer_state_t    state;
  logic [LEN_W-1:0] remaining;
  logic             issued_q;
  logic [CNT_W-1:0] pack_cnt;
  logic             move;
  logic             hold_free;
  logic             no_stall;
  logic             issue;

  // While a word waits in hold, stop before the in-flight bit would fill the pack.
  assign no_stall = !mask_valid ||
                    ((int'(pack_cnt) + int'(issued_q) + 1) < MASK_W);
  assign issue    = (state == RUN) && (remaining != '0) &&
                    a_valid && b_valid && no_stall;
  assign a_ready  = issue;
  assign b_ready  = issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      issued_q  <= 1'b0;
      dut_in1   <= '0;
      dut_in2   <= '0;
      dut_cmd   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      issued_q <= issue;
      if (issue) begin
        dut_in1   <= a_data;
        dut_in2   <= b_data;
        remaining <= remaining - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            dut_cmd   <= op_cmd;
            remaining <= len;
            busy      <= 1'b1;
            state     <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue && (remaining == LEN_W'(1))) state <= FLUSH;
        end
        FLUSH: begin
          if (move || (!issued_q && (pack_cnt == '0))) state <= DONE;
        end
        DONE: begin
          if (hold_free) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  col_cmd_issuer_mask_packer #(
    .MASK_W(MASK_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (issued_q),
    .shift_bit (dut_out),
    .flush     (state == FLUSH),
    .mask_ready(mask_ready),
    .pack_cnt  (pack_cnt),
    .move      (move),
    .hold_free (hold_free),
    .mask_data (mask_data),
    .mask_count(mask_count),
    .mask_valid(mask_valid)
  );

`ifdef COL_ISSUER_POPCOUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      match_count <= '0;
    end else if ((state == IDLE) && start) begin
      match_count <= '0;
    end else if (issued_q && dut_out) begin
      match_count <= match_count + LEN_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_col_cmd_issuer.sv
// tb/tb_col_cmd_issuer.sv - directed self-checking bench for col_cmd_issuer
module tb_col_cmd_issuer;
  import col_cmd_issuer_pkg::*;

  localparam int NUM_SIZE = 32;
  localparam int CMD_W    = 8;
  localparam int MASK_W   = 32;
  localparam int LEN_W    = 16;
  localparam int CNT_W    = 6;

  logic                clk;
  logic                reset;
  logic                start;
  logic [LEN_W-1:0]    len;
  logic [CMD_W-1:0]    op_cmd;
  logic [NUM_SIZE-1:0] a_data, b_data;
  logic                a_valid, b_valid, a_ready, b_ready;
  logic [NUM_SIZE-1:0] dut_in1, dut_in2;
  logic [CMD_W-1:0]    dut_cmd;
  logic                dut_out;
  logic [MASK_W-1:0]   mask_data;
  logic [CNT_W-1:0]    mask_count;
  logic                mask_valid, mask_ready;
  logic                busy, done;
`ifdef COL_ISSUER_POPCOUNT_EN
  logic [LEN_W-1:0]    match_count;
`endif

  col_cmd_issuer #(.MASK_W(MASK_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .op_cmd(op_cmd),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_cmd(dut_cmd), .dut_out(dut_out),
    .mask_data(mask_data), .mask_count(mask_count), .mask_valid(mask_valid),
    .mask_ready(mask_ready), .busy(busy), .done(done)
`ifdef COL_ISSUER_POPCOUNT_EN
    , .match_count(match_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compute unit: combinational on the registered operands, so its result is valid the cycle after issue.
  function automatic logic unit(input logic [NUM_SIZE-1:0] x, input logic [NUM_SIZE-1:0] y,
                                input logic [CMD_W-1:0] c);
    case (c)
      8'd0:    return x[0];
      8'd1:    return x == y;
      8'd2:    return $signed(x) < $signed(y);
      8'd3:    return $signed(x) > $signed(y);
      default: return 1'b0;
    endcase
  endfunction
  assign dut_out = unit(dut_in1, dut_in2, dut_cmd);

  int checks = 0;
  int errors = 0;
  logic [NUM_SIZE-1:0] a_mem [0:127];
  logic [NUM_SIZE-1:0] b_mem [0:127];
  logic [MASK_W-1:0]   got_d [$];
  logic [CNT_W-1:0]    got_c [$];
  int ready_cnt, pair_err, unstable, stall_cyc, done_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input int i, input logic [MASK_W-1:0] d,
                            input logic [CNT_W-1:0] c);
    check({tag, "_data"}, (i < got_d.size()) ? 64'(got_d[i]) : 64'hDEAD, 64'(d));
    check({tag, "_cnt"},  (i < got_c.size()) ? 64'(got_c[i]) : 64'hDEAD, 64'(c));
  endtask

  task automatic run_job(input int n, input logic [CMD_W-1:0] op, input bit toggle_b,
                         input int rdy_delay);
    int idx;
    logic [MASK_W-1:0] prev;
    bit prev_ok;
    got_d.delete();
    got_c.delete();
    ready_cnt = 0; pair_err = 0; unstable = 0; stall_cyc = 0; done_cyc = -1;
    idx = 0; prev = '0; prev_ok = 0;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); op_cmd = op;
    a_valid = 1'b0; b_valid = 1'b0; mask_ready = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start      = 1'b0;
      a_valid    = (idx < n);
      b_valid    = (idx < n) && (!toggle_b || (c % 2 == 1));
      a_data     = (idx < 128) ? a_mem[idx] : '0;
      b_data     = (idx < 128) ? b_mem[idx] : '0;
      mask_ready = (c >= rdy_delay);
      #1;
      if (a_ready !== b_ready) pair_err++;
      if (a_valid && b_valid && !a_ready) stall_cyc++;
      if (a_ready) begin idx++; ready_cnt++; end
      if (mask_valid && !mask_ready) begin
        if (prev_ok && (mask_data !== prev)) unstable++;
        prev = mask_data; prev_ok = 1;
      end
      if (mask_valid && mask_ready) begin
        got_d.push_back(mask_data);
        got_c.push_back(mask_count);
        prev_ok = 0;
      end
      if (done) begin
        done_cyc = c;
        check("busy_at_done", 64'(busy), 64'd0);
        break;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0; mask_ready = 1'b0;
    check("job_finished", 64'(done_cyc > 0), 64'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; len = '0; op_cmd = '0;
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0; mask_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mask_valid", 64'(mask_valid), 64'd0);
    check("rst_dut_cmd", 64'(dut_cmd), 64'd0);
    reset = 1'b0;

    // Five elements, low bit of A: 1,0,1,0,1.
    for (int i = 0; i < 5; i++) begin a_mem[i] = 32'(i + 1); b_mem[i] = '0; end
    run_job(5, NOOP, 1'b0, 0);
    check("t1_words", 64'(got_d.size()), 64'd1);
    check_word("t1_w0", 0, 32'h15, 6'd5);
    check("t1_done_cyc", 64'(done_cyc), 64'd8);
    check("t1_ready_cnt", 64'(ready_cnt), 64'd5);
    check("t1_pair", 64'(pair_err), 64'd0);
`ifdef COL_ISSUER_POPCOUNT_EN
    check("t1_popcount", 64'(match_count), 64'd3);
`endif

    run_job(0, NOOP, 1'b0, 0);
    check("t2_words", 64'(got_d.size()), 64'd0);
    check("t2_ready_cnt", 64'(ready_cnt), 64'd0);
    check("t2_done_cyc", 64'(done_cyc), 64'd2);

    for (int i = 0; i < 40; i++) begin a_mem[i] = 32'd1; b_mem[i] = '0; end
    run_job(40, NOOP, 1'b0, 0);
    check("t3_words", 64'(got_d.size()), 64'd2);
    check_word("t3_w0", 0, 32'hFFFF_FFFF, 6'd32);
    check_word("t3_w1", 1, 32'h0000_00FF, 6'd8);

    // Alternating bits with the result writer blocked long enough to fill the pack behind a held word.
    for (int i = 0; i < 70; i++) begin a_mem[i] = 32'(i); b_mem[i] = '0; end
    run_job(70, NOOP, 1'b0, 80);
    check("t4_words", 64'(got_d.size()), 64'd3);
    check_word("t4_w0", 0, 32'hAAAA_AAAA, 6'd32);
    check_word("t4_w1", 1, 32'hAAAA_AAAA, 6'd32);
    check_word("t4_w2", 2, 32'h0000_002A, 6'd6);
    check("t4_stable", 64'(unstable), 64'd0);
    check("t4_stalled", 64'(stall_cyc > 0), 64'd1);
    check("t4_ready_cnt", 64'(ready_cnt), 64'd70);

    for (int i = 0; i < 5; i++) begin a_mem[i] = 32'(i + 1); b_mem[i] = '0; end
    run_job(5, NOOP, 1'b1, 0);
    check("t5_words", 64'(got_d.size()), 64'd1);
    check_word("t5_w0", 0, 32'h15, 6'd5);
    check("t5_pair", 64'(pair_err), 64'd0);
    check("t5_ready_cnt", 64'(ready_cnt), 64'd5);

    a_mem[0] = -32'sd1; b_mem[0] = 32'd0;
    a_mem[1] = 32'd5;   b_mem[1] = 32'd7;
    a_mem[2] = 32'd3;   b_mem[2] = 32'd3;
    a_mem[3] = -32'sd9; b_mem[3] = -32'sd8;
    run_job(4, CMP_LT, 1'b0, 0);
    check_word("t6_w0", 0, 32'h0000_000B, 6'd4);

    // Reset after three issues of an all-ones job; the next job must see none of those bits.
    for (int i = 0; i < 10; i++) begin a_mem[i] = 32'd1; b_mem[i] = '0; end
    @(negedge clk);
    start = 1'b1; len = LEN_W'(10); op_cmd = NOOP;
    k = 0;
    for (int c = 0; c < 50 && k < 3; c++) begin
      @(negedge clk);
      start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 32'd1; b_data = '0;
      mask_ready = 1'b1;
      #1;
      if (a_ready) k++;
    end
    check("t7_issued", 64'(k), 64'd3);
    @(negedge clk);
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; mask_ready = 1'b0;
    @(posedge clk);
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_a_ready", 64'(a_ready), 64'd0);
    check("t7_in1", 64'(dut_in1), 64'd0);
    check("t7_mask", 64'({mask_valid, mask_count, done}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    a_mem[0] = 32'd2; a_mem[1] = 32'd1; b_mem[0] = '0; b_mem[1] = '0;
    run_job(2, NOOP, 1'b0, 0);
    check("t7_words", 64'(got_d.size()), 64'd1);
    check_word("t7_w0", 0, 32'h0000_0002, 6'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
